// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Owns the single register-file write port (WE3/A3/WD3). The port is shared by
// the in-order pipeline writeback result and a long-latency unit such as
// mul/div. Long-latency results wait in a small FIFO and retire in free
// writeback slots. A starvation counter forces a one-cycle writeback stall so
// that buffered results always drain.
//
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   RegWriteW, RdW,       pipeline writeback request (write enable, destination,
//   ResultW               data)
//   lu_valid, lu_rd,      long-latency unit result handshake
//   lu_data, lu_ready
//   WE3, A3, WD3          register-file write port
//   StallW                holds the writeback stage for this cycle
//   lu_pending            FIFO non-empty
//
// Optional build macro WB_BYPASS_EN: when the FIFO is empty and the pipeline is
// not writing, a unit result with a non-zero rd goes straight to the port in
// the same cycle and is not enqueued.
//
// state | meaning
// IDLE  | FIFO empty
// PEND  | FIFO non-empty, pipeline allowed to win the port
// FORCE | starve limit reached; FIFO head takes the port, pipeline stalled

module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        StallW,
  output logic        lu_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;

  logic pipe_req;
  logic fifo_ne;
  logic lu_push;
  logic pop;
  logic pipe_win;
  logic bypass;
  logic enq;

  assign pipe_req   = RegWriteW & (RdW != 5'd0);
  assign fifo_ne    = (count_q != '0);
  // Registered count only: a pop this cycle does not make room for a push.
  assign lu_ready   = ~rst & (count_q != COUNT_FULL);
  assign lu_pending = ~rst & fifo_ne;
  assign lu_push    = lu_valid & lu_ready;
  // rd=0 results complete the handshake but never occupy a slot.
  assign enq        = lu_push & (lu_rd != 5'd0) & ~bypass;

  // Port grant
  always_comb begin
    WE3      = 1'b0;
    A3       = 5'd0;
    WD3      = 32'd0;
    StallW   = 1'b0;
    pop      = 1'b0;
    pipe_win = 1'b0;
    bypass   = 1'b0;
    if (rst) begin
      pop = 1'b0;
    end else if (state_q == FORCE) begin
      StallW = 1'b1;
      pop    = 1'b1;
    end else if (pipe_req) begin
      pipe_win = 1'b1;
      WE3      = 1'b1;
      A3       = RdW;
      WD3      = ResultW;
    end else if (fifo_ne) begin
      pop = 1'b1;
`ifdef WB_BYPASS_EN
    end else if (lu_valid && (count_q != COUNT_FULL) && (lu_rd != 5'd0)) begin
      bypass = 1'b1;
      WE3    = 1'b1;
      A3     = lu_rd;
      WD3    = lu_data;
`endif
    end
    // A killed entry still pops, but with the write suppressed.
    if (pop && ent_vld_q[rptr_q]) begin
      WE3 = 1'b1;
      A3  = ent_rd_q[rptr_q];
      WD3 = ent_data_q[rptr_q];
    end
  end

  // Next state
  always_comb begin
    count_d  = count_q + CW'(enq) - CW'(pop);
    wptr_d   = wptr_q + PW'(enq);
    rptr_d   = rptr_q + PW'(pop);
    state_d  = state_q;
    starve_d = starve_q;

    if (pop) begin
      starve_d = '0;
    end else if (state_q == PEND && pipe_win) begin
      starve_d = starve_q + SW'(1);
    end

    if (count_d == '0) begin
      state_d  = IDLE;
      starve_d = '0;
    end else if (state_q == PEND && pipe_win && starve_q == STARVE_TOP) begin
      state_d = FORCE;
    end else begin
      state_d = PEND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      starve_q  <= '0;
      ent_vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= 5'd0;
        ent_data_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      starve_q <= starve_d;
      // A pipeline write makes older buffered results to the same rd stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_win && ent_rd_q[i] == RdW) begin
          ent_vld_q[i] <= 1'b0;
        end
      end
      // The same-cycle push is younger than the pipeline write, so it wins.
      if (enq) begin
        ent_rd_q[wptr_q]   <= lu_rd;
        ent_data_q[wptr_q] <= lu_data;
        ent_vld_q[wptr_q]  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port (WE3/A3/WD3) and shares it between two requesters: the in-order pipeline writeback result, and a long-latency unit such as the multiply/divide unit.
- Long-latency results are held in a small FIFO and retired in free writeback slots.
- A starvation counter forces a one-cycle writeback stall so buffered results always drain.
- Sits between the writeback-stage result mux and the register file.

Parameters:
- DEPTH, 2, number of entries in the long-latency result FIFO; power of two, minimum 2.
- STARVE_MAX, 4, number of consecutive cycles the pipeline may win the port while the FIFO is non-empty before a forced drain.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- RegWriteW  input  1  pipeline writeback write-enable.
- RdW  input  5  pipeline destination register.
- ResultW  input  32  pipeline writeback data.
- lu_valid  input  1  long-latency unit result valid.
- lu_rd  input  5  long-latency unit destination register.
- lu_data  input  32  long-latency unit result data.
- lu_ready  output  1  FIFO can accept a result this cycle.
- WE3  output  1  register-file write enable.
- A3  output  5  register-file write address.
- WD3  output  32  register-file write data.
- StallW  output  1  holds the writeback stage for this cycle; the pipeline presents the same RegWriteW/RdW/ResultW next cycle.
- lu_pending  output  1  FIFO non-empty.

Behaviour:
- Reset, while rst is high:
  - FIFO count, pointers and starve counter are cleared; state is IDLE.
  - WE3=0, A3=0, WD3=0, StallW=0, lu_ready=0, lu_pending=0.
  - Reset mid-operation discards all buffered results.
  - lu_ready rises in the first cycle after rst falls.
- Derived signals:
  - pipe_req = RegWriteW & (RdW != 0).
  - lu_push = lu_valid & lu_ready.
  - lu_ready = (count != DEPTH), taken from registered count only (no same-cycle pop-through).
- Write with lu_rd=0 is accepted (handshake completes) but not enqueued.
- States:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty, pipeline allowed to win.
  - FORCE: starve counter reached STARVE_MAX.
- Port grant, evaluated combinationally each cycle:
  - FORCE: StallW=1; FIFO head drives the port (WE3=1, A3=head rd, WD3=head data); head is popped; pipeline write is not performed.
  - Otherwise, if pipe_req: pipeline drives the port, StallW=0.
  - Otherwise, if the FIFO is non-empty: FIFO head drives the port and is popped.
  - Otherwise: WE3=0; A3 and WD3 hold 0.
- Starve counter:
  - Increments on each cycle in PEND where pipe_req wins.
  - Clears on any FIFO pop, and on entering IDLE.
- Transitions:
  - IDLE->PEND on a push.
  - PEND->FORCE when the counter equals STARVE_MAX-1 and pipe_req wins again.
  - FORCE->PEND after one cycle if entries remain, else FORCE->IDLE.
  - PEND->IDLE when the last entry pops with no push.
- Latency: a pipeline write reaches the port in the same cycle. A long-latency result reaches it at the earliest one cycle after its push.
- Stale-result kill:
  - Any buffered entry whose rd equals RdW in a cycle where the pipeline wins the port is marked invalid (per-entry valid bit).
  - Invalid entries pop with WE3=0 and still consume their slot and clear the starve counter.
  - A same-cycle push with lu_rd==RdW is not killed, because the unit result is the younger one.
- Simultaneous push and pop: count is unchanged and the pointers both advance.
- Pointers wrap modulo DEPTH.
- lu_pending = (count != 0), from registered count.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_req=0 and lu_push with lu_rd!=0, the unit result drives the port in the same cycle (WE3=1, A3=lu_rd, WD3=lu_data) and is not enqueued. Latency is 0 cycles.
- Undefined: every unit result is enqueued, with a minimum latency of 1 cycle.

Test Plan:
- Reset asserted mid-drain with 2 entries buffered -> all outputs 0 immediately; after release, lu_ready=1, lu_pending=0, and no write of the old entries occurs.
- Free port: push (rd=5, data=0xDEADBEEF) with RegWriteW=0 -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF, lu_pending falls.
- FIFO full: push two entries while pipe_req=1 continuously -> lu_ready=0 with count=2; a third lu_valid is held off until the first pop.
- Starvation: 1 entry buffered, pipe_req=1 with distinct RdW every cycle -> StallW=1 on the 5th cycle (STARVE_MAX=4) with the FIFO entry on the port; StallW=0 afterwards.
- Stale kill: buffer rd=7 data=0x11, then pipeline writes rd=7 data=0x22 -> the later drain cycle shows WE3=0, and the register file ends holding 0x22.
- lu_rd=0 push -> handshake completes, lu_pending stays 0, and no WE3 is produced. With WB_BYPASS_EN, a push of rd=3 into an empty FIFO on an idle cycle gives a same-cycle WE3=1, A3=3.
